// File: rtl/param_stack.sv
// LIFO stack with a combinational top-of-stack peek and a registered pop output.
// Define PARAM_STACK_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stack_empty,
  output logic                       stack_full,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CW-1:0]    top_ptr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_entry;
  logic             empty, full;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign top_ptr   = count_q - CW'(1);
  assign top_idx   = top_ptr[AW-1:0];
  assign top_entry = mem_q[top_idx];

  always_comb begin
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = count_q[AW-1:0];
    if (push && pop) begin
      if (!empty) begin
        // Replace: hand out the old top and overwrite it in place.
        data_out_d   = top_entry;
        data_valid_d = 1'b1;
        wr_en        = 1'b1;
        wr_addr      = top_idx;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (push) begin
      if (!full) begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        data_out_d   = top_entry;
        data_valid_d = 1'b1;
        count_d      = top_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointer matters.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign count       = count_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign top         = empty ? '0 : top_entry;

`ifdef PARAM_STACK_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (push && !pop && full) overflow_d = 1'b1;
    if (pop && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- WIDTH, 8, data width in bits; legal range ≥1.
- DEPTH, 16, number of entries; legal range ≥2; need not be a power of two.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- push, in, 1, write request.
- pop, in, 1, read request.
- data_in, in, WIDTH, push data.
- data_out, out, WIDTH, registered popped data.
- data_valid, out, 1, one-cycle pulse marking data_out updated by an accepted pop.
- top, out, WIDTH, combinational peek of the current top entry; 0 when empty.
- count, out, $clog2(DEPTH+1), current occupancy.
- stack_empty, out, 1, high when count==0.
- stack_full, out, 1, high when count==DEPTH.
- err_clr, in, 1, clears sticky error flags.
- overflow, out, 1, sticky push-while-full flag.
- underflow, out, 1, sticky pop-while-empty flag.
REQ-003 One clock domain; reset is synchronous and active-high; the clock port is named clk and the reset port is named reset.

Function
REQ-004 Storage SHALL be a DEPTH x WIDTH register array indexed by a stack pointer sp equal to count; the top entry is mem[sp-1].
REQ-005 Accepted push only, when not full: mem[sp] <= data_in and count increments by 1 at the same edge.
REQ-006 Accepted pop only, when not empty: data_out <= mem[sp-1], data_valid is high for the following cycle, and count decrements by 1; latency from pop sampled to data_out valid is 1 cycle.
REQ-007 Push and pop together, when not empty (including full): replace operation.
- data_out <= old top, data_valid pulses.
- mem[sp-1] <= data_in.
- count is unchanged; no overflow is flagged, even when full.
REQ-008 Push and pop together, when empty: the push is accepted (count becomes 1), the pop is rejected, and data_valid stays low.
REQ-009 Push while full without pop: the push is ignored, and memory and count are unchanged.
REQ-010 Pop while empty without push: the pop is ignored, data_out holds its previous value, and data_valid stays low.
REQ-011 data_out SHALL hold its value between accepted pops.
REQ-012 stack_empty, stack_full and top SHALL be derived from the registered count and memory with no added latency.
REQ-013 Memory contents are not cleared by reset; only the pointer and outputs are reset.

Reset
REQ-014 While reset is sampled high at the clock edge:
- count=0, so stack_empty=1 and stack_full=0.
- data_out=0, data_valid=0, overflow=0, underflow=0.
REQ-015 Reset SHALL override push, pop and err_clr in the same cycle; a reset issued mid-operation discards all stacked entries.

Configuration
REQ-016 The macro PARAM_STACK_ERR_FLAGS_EN gates the error-flag logic.
- Defined: overflow sets on a rejected push (REQ-009) and underflow sets on a rejected pop (REQ-008, REQ-010); both are sticky until err_clr or reset.
- err_clr clears both flags; if err_clr and a new error occur in the same cycle, the set wins.
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and no flag registers are inferred.
REQ-017 All other behaviour SHALL be identical with or without the macro.

Verification (WIDTH=8, DEPTH=4)
REQ-018 Reset then idle: count=0, stack_empty=1, stack_full=0, data_out=0x00, data_valid=0, top=0x00.
REQ-019 Push 0xAA, 0xCC, 0x11, 0x22 on consecutive cycles: count=4, stack_full=1, top=0x22. Then pop 4 times: data_out sequence 0x22, 0x11, 0xCC, 0xAA, each with a data_valid pulse; final stack_empty=1.
REQ-020 Full stack, push 0x55 with no pop: count stays 4 and top stays 0x22. With the macro, overflow=1 until err_clr is pulsed, then 0; without the macro, overflow=0 throughout.
REQ-021 Stack holding 0xAA,0xCC, push 0x77 and pop in the same cycle: data_out=0xCC, data_valid=1, count=2, top=0x77. Repeat on a full stack: count remains 4 and overflow stays 0.
REQ-022 Empty stack, push 0x3C and pop in the same cycle: count=1, top=0x3C, data_valid=0, and underflow=1 with the macro; a subsequent pop alone gives data_out=0x3C.
REQ-023 Push 0xAA, 0xCC, assert reset for one cycle together with push 0x99: count=0, data_out=0x00, and the flags clear; the next pop is rejected with data_valid=0.
